// File: rtl/light_pen_locator_pkg.sv
// Shared constants for the light-pen locator: FSM encodings, default thresholds
// and small scan-vector helpers.
package light_pen_locator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEARCH  = 2'd1,
    ST_CONFIRM = 2'd2,
    ST_TRACK   = 2'd3
  } pen_state_e;

  localparam int SAMPLE_W_DEF       = 8;
  localparam int HIT_MIN_DEF        = 4;
  localparam int CONFIRM_FRAMES_DEF = 2;
  localparam int LOST_FRAMES_DEF    = 3;

  // Width of the frame-granular confirm/miss counters.
  localparam int FRAME_CNT_W = 8;

  function automatic logic is_onehot8(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  function automatic logic [2:0] encode8(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/light_pen_locator_pixel_sampler.sv
// Per-pixel dwell sampler: synchronises the pen input, counts high samples
// during each dwell and reports hit/row/col when the dwell closes.
module pen_pixel_sampler
  import light_pen_locator_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int HIT_MIN  = HIT_MIN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_in,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  input  logic       scan_tick,
  input  logic       frame_start,
  output logic       dwell_hit,
  output logic [2:0] dwell_row,
  output logic [2:0] dwell_col
);

  localparam logic [SAMPLE_W-1:0] HIT_MIN_C = SAMPLE_W'(HIT_MIN);
  localparam logic [SAMPLE_W-1:0] SAT_MAX   = '1;

  logic [1:0]          sync_reg;
  logic                pen_s;
  logic [SAMPLE_W-1:0] sample_cnt_reg, sample_cnt_next;
  logic [2:0]          row_reg, col_reg;
  logic                onehot_reg;
  logic                tick;

  // A stray frame_start without scan_tick still closes the dwell.
  assign tick  = scan_tick | frame_start;
  assign pen_s = sync_reg[1];

  always_comb begin
    sample_cnt_next = sample_cnt_reg;
    if (tick) begin
      sample_cnt_next = '0;
    end else if (pen_s && (sample_cnt_reg != SAT_MAX)) begin
      sample_cnt_next = sample_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg       <= 2'b00;
      sample_cnt_reg <= '0;
      row_reg        <= 3'd0;
      col_reg        <= 3'd0;
      onehot_reg     <= 1'b0;
    end else begin
      sync_reg       <= {sync_reg[0], pen_in};
      sample_cnt_reg <= sample_cnt_next;
      if (tick) begin
        row_reg    <= encode8(scan_row);
        col_reg    <= encode8(scan_col);
        onehot_reg <= is_onehot8(scan_row) && is_onehot8(scan_col);
      end
    end
  end

  // Outputs describe the dwell that is closing in this tick cycle.
  assign dwell_hit = tick && onehot_reg && (sample_cnt_reg >= HIT_MIN_C);
  assign dwell_row = row_reg;
  assign dwell_col = col_reg;

endmodule

// File: rtl/light_pen_locator.sv
// Light-pen locator: correlates the pen pulse with the scan position, confirms
// a stable pixel over several frames and strobes its address into display RAM.
module light_pen_locator
  import light_pen_locator_pkg::*;
#(
  parameter int SAMPLE_W       = SAMPLE_W_DEF,
  parameter int HIT_MIN        = HIT_MIN_DEF,
  parameter int CONFIRM_FRAMES = CONFIRM_FRAMES_DEF,
  parameter int LOST_FRAMES    = LOST_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pen_in,
  input  logic       pen_en,
  input  logic [7:0] scan_row,
  input  logic [7:0] scan_col,
  input  logic       scan_tick,
  input  logic       frame_start,
  output logic       pen_we,
  output logic [2:0] pen_row,
  output logic [2:0] pen_col,
  output logic       pen_track,
  output logic       pen_lost
);

  localparam logic [FRAME_CNT_W-1:0] CONFIRM_C = FRAME_CNT_W'(CONFIRM_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] LOST_C    = FRAME_CNT_W'(LOST_FRAMES);

  logic       dwell_hit;
  logic [2:0] dwell_row, dwell_col;

  pen_pixel_sampler #(
    .SAMPLE_W (SAMPLE_W),
    .HIT_MIN  (HIT_MIN)
  ) u_sampler (
    .clk         (clk),
    .rst_n       (rst_n),
    .pen_in      (pen_in),
    .scan_row    (scan_row),
    .scan_col    (scan_col),
    .scan_tick   (scan_tick),
    .frame_start (frame_start),
    .dwell_hit   (dwell_hit),
    .dwell_row   (dwell_row),
    .dwell_col   (dwell_col)
  );

  logic       frame_hit_reg;
  logic [2:0] frame_row_reg, frame_col_reg;
  logic       eval_hit;
  logic [2:0] eval_row, eval_col;

  // The last dwell of a frame closes on the same cycle as frame_start, so it is
  // folded in combinationally ahead of evaluation.
  always_comb begin
    eval_hit = frame_hit_reg | dwell_hit;
    eval_row = frame_hit_reg ? frame_row_reg : dwell_row;
    eval_col = frame_hit_reg ? frame_col_reg : dwell_col;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_hit_reg <= 1'b0;
      frame_row_reg <= 3'd0;
      frame_col_reg <= 3'd0;
    end else if (frame_start) begin
      frame_hit_reg <= 1'b0;
      frame_row_reg <= 3'd0;
      frame_col_reg <= 3'd0;
    end else if (dwell_hit && !frame_hit_reg) begin
      frame_hit_reg <= 1'b1;
      frame_row_reg <= dwell_row;
      frame_col_reg <= dwell_col;
    end
  end

  pen_state_e             state_reg, state_next;
  logic [FRAME_CNT_W-1:0] conf_cnt_reg, conf_cnt_next;
  logic [FRAME_CNT_W-1:0] miss_cnt_reg, miss_cnt_next;
  logic [2:0]             cand_row_reg, cand_row_next;
  logic [2:0]             cand_col_reg, cand_col_next;
  logic                   pen_we_reg, pen_we_next;
  logic                   pen_lost_reg, pen_lost_next;
  logic [2:0]             pen_row_reg, pen_row_next;
  logic [2:0]             pen_col_reg, pen_col_next;

  always_comb begin
    state_next    = state_reg;
    conf_cnt_next = conf_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    cand_row_next = cand_row_reg;
    cand_col_next = cand_col_reg;
    pen_we_next   = 1'b0;
    pen_lost_next = 1'b0;
    pen_row_next  = pen_row_reg;
    pen_col_next  = pen_col_reg;

    if (!pen_en) begin
      state_next    = ST_IDLE;
      conf_cnt_next = '0;
      miss_cnt_next = '0;
    end else if (frame_start) begin
      unique case (state_reg)
        ST_IDLE: begin
          // The partial frame seen while idle is discarded.
          state_next    = ST_SEARCH;
          conf_cnt_next = '0;
          miss_cnt_next = '0;
        end
        ST_SEARCH: begin
          if (eval_hit) begin
            cand_row_next = eval_row;
            cand_col_next = eval_col;
            conf_cnt_next = FRAME_CNT_W'(1);
            if (CONFIRM_FRAMES <= 1) begin
              state_next    = ST_TRACK;
              miss_cnt_next = '0;
              pen_we_next   = 1'b1;
              pen_row_next  = eval_row;
              pen_col_next  = eval_col;
            end else begin
              state_next = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (!eval_hit) begin
            state_next    = ST_SEARCH;
            conf_cnt_next = '0;
          end else if ({eval_row, eval_col} == {cand_row_reg, cand_col_reg}) begin
            conf_cnt_next = conf_cnt_reg + 1'b1;
            if ((conf_cnt_reg + 1'b1) >= CONFIRM_C) begin
              state_next    = ST_TRACK;
              miss_cnt_next = '0;
              pen_we_next   = 1'b1;
              pen_row_next  = eval_row;
              pen_col_next  = eval_col;
            end
          end else begin
            cand_row_next = eval_row;
            cand_col_next = eval_col;
            conf_cnt_next = FRAME_CNT_W'(1);
          end
        end
        ST_TRACK: begin
          if (eval_hit) begin
            miss_cnt_next = '0;
            pen_we_next   = 1'b1;
            pen_row_next  = eval_row;
            pen_col_next  = eval_col;
          end else if ((miss_cnt_reg + 1'b1) >= LOST_C) begin
            state_next    = ST_SEARCH;
            miss_cnt_next = '0;
            conf_cnt_next = '0;
            pen_lost_next = 1'b1;
          end else begin
            miss_cnt_next = miss_cnt_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      conf_cnt_reg <= '0;
      miss_cnt_reg <= '0;
      cand_row_reg <= 3'd0;
      cand_col_reg <= 3'd0;
      pen_we_reg   <= 1'b0;
      pen_lost_reg <= 1'b0;
      pen_row_reg  <= 3'd0;
      pen_col_reg  <= 3'd0;
    end else begin
      state_reg    <= state_next;
      conf_cnt_reg <= conf_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
      cand_row_reg <= cand_row_next;
      cand_col_reg <= cand_col_next;
      pen_we_reg   <= pen_we_next;
      pen_lost_reg <= pen_lost_next;
      pen_row_reg  <= pen_row_next;
      pen_col_reg  <= pen_col_next;
    end
  end

  assign pen_we    = pen_we_reg;
  assign pen_lost  = pen_lost_reg;
  assign pen_row   = pen_row_reg;
  assign pen_col   = pen_col_reg;
  assign pen_track = (state_reg == ST_TRACK);

endmodule

// File: tb/tb_light_pen_locator.sv
// Frame-level bench for light_pen_locator: a table of scanned frames with the
// outputs expected right after each frame_start, checked through a scoreboard.
module tb_light_pen_locator;

  localparam int DWELL = 10;

  logic       clk;
  logic       rst_n;
  logic       pen_in;
  logic       pen_en;
  logic [7:0] scan_row;
  logic [7:0] scan_col;
  logic       scan_tick;
  logic       frame_start;
  logic       pen_we;
  logic [2:0] pen_row;
  logic [2:0] pen_col;
  logic       pen_track;
  logic       pen_lost;

  light_pen_locator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pen_in      (pen_in),
    .pen_en      (pen_en),
    .scan_row    (scan_row),
    .scan_col    (scan_col),
    .scan_tick   (scan_tick),
    .frame_start (frame_start),
    .pen_we      (pen_we),
    .pen_row     (pen_row),
    .pen_col     (pen_col),
    .pen_track   (pen_track),
    .pen_lost    (pen_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       we;
    logic [2:0] row;
    logic [2:0] col;
    logic       track;
    logic       lost;
  } exp_t;

  // One frame of stimulus (pen lit in up to two pixels) plus the outputs
  // expected just after that frame's own frame_start edge.
  typedef struct {
    logic en;
    int   ar, ac, alen;
    int   br, bc, blen;
    logic bad_col;
    exp_t e;
  } rec_t;

  int   errors;
  int   checks;
  exp_t sb_q[$];
  rec_t tbl[$];

  function automatic rec_t mk(input logic en, input int ar, input int ac, input int alen,
                              input int br, input int bc, input int blen, input logic bad,
                              input logic we, input int row, input int col,
                              input logic track, input logic lost);
    rec_t r;
    r.en = en; r.ar = ar; r.ac = ac; r.alen = alen;
    r.br = br; r.bc = bc; r.blen = blen; r.bad_col = bad;
    r.e.we = we; r.e.row = 3'(row); r.e.col = 3'(col);
    r.e.track = track; r.e.lost = lost;
    return r;
  endfunction

  function automatic exp_t observed();
    return {pen_we, pen_row, pen_col, pen_track, pen_lost};
  endfunction

  task automatic drive_cycle(input int p, input int d, input logic en, input rec_t r);
    int   row, col;
    logic lit;
    row = p / 8;
    col = p % 8;
    scan_row = 8'd1 << row;
    scan_col = 8'd1 << col;
    if (r.bad_col && row == r.ar && col == r.ac) scan_col = 8'h03;
    lit = 1'b0;
    if (r.alen > 0 && row == r.ar && col == r.ac && d >= 1 && d < 1 + r.alen) lit = 1'b1;
    if (r.blen > 0 && row == r.br && col == r.bc && d >= 1 && d < 1 + r.blen) lit = 1'b1;
    pen_in      = lit;
    pen_en      = en;
    scan_tick   = (d == 0);
    frame_start = (p == 0 && d == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_eval(input string name);
    exp_t e, g;
    checks++;
    g = observed();
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got we=%0b row=%0d col=%0d track=%0b lost=%0b",
               name, g.we, g.row, g.col, g.track, g.lost);
      return;
    end
    e = sb_q.pop_front();
    if (g !== e) begin
      errors++;
      $display("FAIL %s: got we=%0b row=%0d col=%0d track=%0b lost=%0b, want we=%0b row=%0d col=%0d track=%0b lost=%0b",
               name, g.we, g.row, g.col, g.track, g.lost, e.we, e.row, e.col, e.track, e.lost);
    end else begin
      $display("%s: we=%0b row=%0d col=%0d track=%0b lost=%0b ok",
               name, g.we, g.row, g.col, g.track, g.lost);
    end
  endtask

  task automatic run_frame(input int k, input rec_t r);
    int stray;
    stray = 0;
    for (int p = 0; p < 64; p++) begin
      for (int d = 0; d < DWELL; d++) begin
        if (p == 0 && d == 0) sb_q.push_back(r.e);
        drive_cycle(p, d, r.en, r);
        if (p == 0 && d == 0) check_eval($sformatf("frame %0d eval", k));
        else if (pen_we || pen_lost) stray++;
      end
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL frame %0d quiet: got %0d stray we/lost cycles, want 0", k, stray);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t none_on, none_off;
    exp_t g;
    errors = 0;
    checks = 0;
    rst_n = 1'b0; pen_in = 1'b0; pen_en = 1'b0;
    scan_row = 8'd0; scan_col = 8'd0; scan_tick = 1'b0; frame_start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      pen_in = i[0];
      @(posedge clk);
      #1;
    end
    checks++;
    g = observed();
    if (g !== 9'd0) begin
      errors++;
      $display("FAIL reset: got outputs %b, want 0", g);
    end else begin
      $display("reset: outputs all zero ok");
    end
    rst_n = 1'b1;

    //            en  A(r,c,len)  B(r,c,len)  bad  | we row col trk lost
    tbl.push_back(mk(0, 2, 5, 6, -1, -1, 0, 0,  0, 0, 0, 0, 0)); // 0  idle
    tbl.push_back(mk(0, 2, 5, 6, -1, -1, 0, 0,  0, 0, 0, 0, 0)); // 1
    tbl.push_back(mk(0, 2, 5, 6, -1, -1, 0, 0,  0, 0, 0, 0, 0)); // 2
    tbl.push_back(mk(1, 2, 5, 6, -1, -1, 0, 0,  0, 0, 0, 0, 0)); // 3  -> SEARCH
    tbl.push_back(mk(1, 2, 5, 6, -1, -1, 0, 0,  0, 0, 0, 0, 0)); // 4  -> CONFIRM
    tbl.push_back(mk(1, 2, 5, 6, -1, -1, 0, 0,  1, 2, 5, 1, 0)); // 5  -> TRACK
    tbl.push_back(mk(1, 2, 5, 3, -1, -1, 0, 0,  1, 2, 5, 1, 0)); // 6  glitch frame
    tbl.push_back(mk(1, 2, 5, 4, -1, -1, 0, 0,  0, 2, 5, 1, 0)); // 7  glitch no hit
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 1, 2, 5, 1, 0)); // 8  4-cycle hit
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 2, 5, 1, 0)); // 9  miss 1
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 2, 5, 1, 0)); // 10 miss 2
    tbl.push_back(mk(1, 2, 5, 6, -1, -1, 0, 0,  0, 2, 5, 0, 1)); // 11 lost
    tbl.push_back(mk(1, 3, 3, 6, -1, -1, 0, 0,  0, 2, 5, 0, 0)); // 12 cand (2,5)
    tbl.push_back(mk(1, 3, 3, 6, -1, -1, 0, 0,  0, 2, 5, 0, 0)); // 13 cand -> (3,3)
    tbl.push_back(mk(1, 3, 3, 6, -1, -1, 0, 0,  1, 3, 3, 1, 0)); // 14 TRACK (3,3)
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 1, 3, 3, 1, 0)); // 15
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 3, 3, 1, 0)); // 16 miss 1
    tbl.push_back(mk(1, 7, 7, 6, -1, -1, 0, 0,  0, 3, 3, 1, 0)); // 17 miss 2
    tbl.push_back(mk(1, 1, 1, 6, 4, 4, 6, 0,    1, 7, 7, 1, 0)); // 18 last pixel hit
    tbl.push_back(mk(1, 0, 2, 6, -1, -1, 0, 1,  1, 1, 1, 1, 0)); // 19 first of two hits
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 1, 1, 1, 0)); // 20 col 8'h03 miss
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 1, 1, 1, 0)); // 21 miss 2
    tbl.push_back(mk(1, 5, 0, 6, -1, -1, 0, 0,  0, 1, 1, 0, 1)); // 22 lost
    tbl.push_back(mk(1, 4, 6, 3, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 23 -> CONFIRM
    tbl.push_back(mk(1, 5, 0, 6, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 24 glitch -> SEARCH
    tbl.push_back(mk(1, 5, 0, 6, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 25 -> CONFIRM
    tbl.push_back(mk(0, 5, 0, 6, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 26 en falls at fs
    tbl.push_back(mk(0, -1, -1, 0, -1, -1, 0, 0, 0, 1, 1, 0, 0)); // 27
    tbl.push_back(mk(1, 6, 6, 6, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 28 -> SEARCH
    tbl.push_back(mk(1, 6, 6, 6, -1, -1, 0, 0,  0, 1, 1, 0, 0)); // 29 -> CONFIRM
    tbl.push_back(mk(1, 6, 6, 6, -1, -1, 0, 0,  1, 6, 6, 1, 0)); // 30 -> TRACK
    tbl.push_back(mk(1, -1, -1, 0, -1, -1, 0, 0, 1, 6, 6, 1, 0)); // 31

    for (int k = 0; k < tbl.size(); k++) run_frame(k, tbl[k]);

    // Drop pen_en in the middle of a tracking frame.
    none_on  = mk(1, -1, -1, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0);
    none_off = mk(0, -1, -1, 0, -1, -1, 0, 0, 0, 0, 0, 0, 0);
    sb_q.push_back(exp_t'({1'b0, 3'd6, 3'd6, 1'b1, 1'b0}));
    drive_cycle(0, 0, 1'b1, none_on);
    check_eval("frame 32 eval");
    for (int d = 1; d < DWELL; d++) drive_cycle(0, d, 1'b1, none_on);
    checks++;
    if (pen_track !== 1'b1) begin
      errors++;
      $display("FAIL track before drop: got %0b, want 1", pen_track);
    end else begin
      $display("track before drop: pen_track=1 ok");
    end
    drive_cycle(1, 0, 1'b0, none_off);
    checks++;
    if (pen_track !== 1'b0) begin
      errors++;
      $display("FAIL track after drop: got %0b, want 0", pen_track);
    end else begin
      $display("track after drop: pen_track=0 ok");
    end
    for (int d = 1; d < DWELL; d++) drive_cycle(1, d, 1'b0, none_off);
    sb_q.push_back(exp_t'({1'b0, 3'd6, 3'd6, 1'b0, 1'b0}));
    drive_cycle(0, 0, 1'b0, none_off);
    check_eval("frame 33 eval idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
